// File: rtl/fifo_btn_ctrl.sv
// Button levels -> one-shot/auto-repeat FIFO strobes, round-robin arbitrated and gated by full/empty.
// Latency: press sampled at edge N -> strobe/drop during cycle N+2; no backpressure, a gated request becomes a drop pulse.
module fifo_btn_ctrl #(
  parameter int DW         = 8,
  parameter int REPEAT_DLY = 5_000_000,
  parameter int REPEAT_PER = 2_000_000,
  parameter int CW         = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_btn,
  input  logic          rd_btn,
  input  logic [DW-1:0] sw_data,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_wr_data,
  output logic          fifo_rd_en,
  output logic          wr_drop,
  output logic          rd_drop
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RPT  = 2'd2;

  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);

  // Channel index 0 is write, 1 is read throughout.
  logic [1:0] btn;
  logic [1:0] btn_q;
  logic [1:0] rise;
  logic [1:0] set_pend;
  logic [1:0] pend;
  logic [1:0] gnt;
  logic       last_rd;

  logic [1:0]    gnt_q;
  logic [DW-1:0] gnt_data;
  logic          gnt_full;
  logic          gnt_empty;

  assign btn  = {rd_btn, wr_btn};
  assign rise = btn & ~btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= '0;
    else     btn_q <= btn;
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [1:0]    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise[c]) begin
              state <= ST_HOLD;
              cnt   <= '0;
            end
          end
          ST_HOLD: begin
            if (!btn[c]) begin
              state <= ST_IDLE;
            end else if (cnt == DLY_LAST) begin
              state <= ST_RPT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_RPT: begin
            if (!btn[c]) begin
              state <= ST_IDLE;
            end else if (cnt == PER_LAST) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    assign set_pend[c] = ((state == ST_IDLE) && rise[c]) ||
                         ((state == ST_HOLD) && btn[c] && (cnt == DLY_LAST)) ||
                         ((state == ST_RPT)  && btn[c] && (cnt == PER_LAST));
  end

  // With both pending, the channel that did not win last time goes first.
  always_comb begin
    gnt = pend;
    if (pend == 2'b11) gnt = last_rd ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      last_rd   <= 1'b1;
      gnt_q     <= '0;
      gnt_data  <= '0;
      gnt_full  <= 1'b0;
      gnt_empty <= 1'b0;
    end else begin
      // A new request on the granting edge survives the clear and merges.
      pend      <= (pend & ~gnt) | set_pend;
      gnt_q     <= gnt;
      gnt_full  <= fifo_full;
      gnt_empty <= fifo_empty;
      if (gnt[0]) gnt_data <= sw_data;
      if (gnt != 2'b00) last_rd <= gnt[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      fifo_rd_en   <= 1'b0;
      wr_drop      <= 1'b0;
      rd_drop      <= 1'b0;
    end else begin
      fifo_wr_en <= gnt_q[0] & ~gnt_full;
      wr_drop    <= gnt_q[0] &  gnt_full;
      fifo_rd_en <= gnt_q[1] & ~gnt_empty;
      rd_drop    <= gnt_q[1] &  gnt_empty;
      if (gnt_q[0] && !gnt_full) fifo_wr_data <= gnt_data;
    end
  end

endmodule

// File: tb/tb_fifo_btn_ctrl.sv
// Directed bench for fifo_btn_ctrl with short repeat timing (delay 8, period 4).
module tb_fifo_btn_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_btn;
  logic       rd_btn;
  logic [7:0] sw_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       fifo_rd_en;
  logic       wr_drop;
  logic       rd_drop;

  int errors  = 0;
  int checks  = 0;
  int overlap = 0;

  fifo_btn_ctrl #(
    .DW(8), .REPEAT_DLY(8), .REPEAT_PER(4), .CW(4)
  ) dut (
    .clk(clk), .rst(rst), .wr_btn(wr_btn), .rd_btn(rd_btn), .sw_data(sw_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_rd_en(fifo_rd_en), .wr_drop(wr_drop),
    .rd_drop(rd_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (fifo_wr_en && fifo_rd_en) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wr_en"}, fifo_wr_en, 0);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_wr_drop"}, wr_drop, 0);
    check({tag, "_rd_drop"}, rd_drop, 0);
  endtask

  initial begin
    rst = 1'b1; wr_btn = 0; rd_btn = 0; sw_data = 8'h00;
    fifo_full = 0; fifo_empty = 0;
    idle(2);
    check_quiet("reset");
    check("reset_wr_data", fifo_wr_data, 8'h00);
    rst = 1'b0;
    idle(2);

    // T1: single write; sw_data changes right after the grant edge.
    sw_data = 8'hA5; wr_btn = 1;
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("t1_wr_en_k%0d", k), fifo_wr_en, (k == 2));
      check($sformatf("t1_rd_en_k%0d", k), fifo_rd_en, 0);
      if (k == 2) check("t1_data", fifo_wr_data, 8'hA5);
      if (k == 1) sw_data = 8'h3C;
      if (k == 2) wr_btn = 0;
    end
    check("t1_data_hold", fifo_wr_data, 8'hA5);
    idle(3);

    // T2: hold read 20 cycles -> +2, +10, +14, +18.
    rd_btn = 1;
    for (int k = 0; k < 24; k++) begin
      step();
      check($sformatf("t2_rd_en_k%0d", k), fifo_rd_en,
            (k == 2 || k == 10 || k == 14 || k == 18));
      if (k == 19) rd_btn = 0;
    end
    idle(3);

    // T3: simultaneous rise, last grant was read -> write first.
    wr_btn = 1; rd_btn = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("t3_wr_en_k%0d", k), fifo_wr_en, (k == 2));
      check($sformatf("t3_rd_en_k%0d", k), fifo_rd_en, (k == 3));
      if (k == 0) begin wr_btn = 0; rd_btn = 0; end
    end
    idle(3);

    // T4: gating against full and empty.
    fifo_full = 1; wr_btn = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("t4_wr_drop_k%0d", k), wr_drop, (k == 2));
      check($sformatf("t4_wr_en_k%0d", k), fifo_wr_en, 0);
      if (k == 0) wr_btn = 0;
    end
    fifo_full = 0;
    idle(2);
    fifo_empty = 1; rd_btn = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("t4_rd_drop_k%0d", k), rd_drop, (k == 2));
      check($sformatf("t4_rd_en_k%0d", k), fifo_rd_en, 0);
      if (k == 0) rd_btn = 0;
    end
    fifo_empty = 0;
    idle(3);

    // T5: release mid-hold, then a fresh press must work again.
    sw_data = 8'h5A; wr_btn = 1;
    for (int k = 0; k < 15; k++) begin
      step();
      check($sformatf("t5_wr_en_k%0d", k), fifo_wr_en, (k == 2));
      if (k == 4) wr_btn = 0;
    end
    check("t5_data", fifo_wr_data, 8'h5A);
    sw_data = 8'hC3; wr_btn = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("t5b_wr_en_k%0d", k), fifo_wr_en, (k == 2));
      if (k == 0) wr_btn = 0;
    end
    check("t5b_data", fifo_wr_data, 8'hC3);
    idle(3);

    // T6: reset while in auto-repeat with the button held.
    rd_btn = 1;
    idle(14);
    rst = 1'b1;
    #1;
    check_quiet("t6_async");
    step();
    check_quiet("t6_inrst");
    check("t6_wr_data", fifo_wr_data, 8'h00);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("t6_rd_en_k%0d", k), fifo_rd_en, (k == 2));
      if (k == 5) rd_btn = 0;
    end
    idle(2);

    check("no_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
